block_lane_engine: RTL

BLOCK_LANE_ENGINE -- requirements
Module: block_lane_engine

---
 rtl/block_pkg.sv | 32 +++
 rtl/block_lane.sv | 108 ++++++++++
 rtl/block_lane_engine.sv | 97 +++++++++
 3 files changed

// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - shared screen constants, lane state encoding and score helpers
package block_pkg;

  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;
  localparam int Y_W      = 10;
  localparam int X_W      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FALL  = 2'd1,
    ST_FLASH = 2'd2,
    ST_MISS  = 2'd3
  } lane_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'd0, v[k]};
    end
    return n;
  endfunction

  // Totals pin at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/block_lane.sv
// rtl/block_lane.sv - one falling-block lane: state machine, vertical position, edge outputs
module block_lane #(
  parameter int LANE_IDX    = 0,
  parameter int SPEED       = 4,
  parameter int BLOCK_H     = 20,
  parameter int BLOCK_W     = 80,
  parameter int LANE_X0     = 160,
  parameter int LANE_PITCH  = 120,
  parameter int HIT_Y_MIN   = 440,
  parameter int HIT_Y_MAX   = 470,
  parameter int SCREEN_H    = 480,
  parameter int FLASH_TICKS = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      tick_i,
  input  logic                      press_i,
  input  logic                      spawn_i,
  output logic [block_pkg::Y_W-1:0] top_o,
  output logic [block_pkg::Y_W-1:0] bot_o,
  output logic [block_pkg::X_W-1:0] left_o,
  output logic [block_pkg::X_W-1:0] right_o,
  output logic                      active_o,
  output logic                      hit_o,
  output logic                      miss_o
);
  import block_pkg::*;

  localparam logic [X_W-1:0] LEFT_X  = X_W'(LANE_X0 + LANE_IDX * LANE_PITCH);
  localparam logic [X_W-1:0] RIGHT_X = X_W'(LANE_X0 + LANE_IDX * LANE_PITCH + BLOCK_W - 1);

  lane_state_t      state_q;
  logic [Y_W-1:0]   top_q;
  logic [7:0]       flash_cnt_q;
  logic             hit_q;
  logic             miss_q;

  logic [X_W-1:0]   sum_d;
  logic [X_W-1:0]   bot_d;
  logic             in_window;
  logic             shown;

  // 11-bit arithmetic so the bottom-of-screen compare cannot alias through a 10-bit wrap.
  assign sum_d     = {1'b0, top_q} + X_W'(SPEED);
  assign bot_d     = {1'b0, top_q} + X_W'(BLOCK_H - 1);
  assign in_window = (bot_d >= X_W'(HIT_Y_MIN)) && (bot_d <= X_W'(HIT_Y_MAX));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      top_q       <= '0;
      flash_cnt_q <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (spawn_i) begin
            state_q     <= ST_FALL;
            top_q       <= '0;
            flash_cnt_q <= '0;
          end
        end
        ST_FALL: begin
          // A hit in the same cycle as a tick is judged on the pre-tick position.
          if (press_i && in_window) begin
            state_q <= ST_FLASH;
            hit_q   <= 1'b1;
          end else if (tick_i) begin
            if (sum_d >= X_W'(SCREEN_H)) begin
              state_q <= ST_MISS;
              miss_q  <= 1'b1;
            end else begin
              top_q <= sum_d[Y_W-1:0];
            end
          end
        end
        ST_FLASH: begin
          if (tick_i) begin
            if (flash_cnt_q == 8'(FLASH_TICKS - 1)) begin
              state_q <= ST_IDLE;
            end
            flash_cnt_q <= flash_cnt_q + 8'd1;
          end
        end
        ST_MISS: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The block stays on screen at its last position during the one-cycle miss.
  assign shown    = (state_q != ST_IDLE);
  assign active_o = (state_q == ST_FALL) || (state_q == ST_FLASH);
  assign top_o    = shown ? top_q : '0;
  assign bot_o    = shown ? bot_d[Y_W-1:0] : '0;
  assign left_o   = LEFT_X;
  assign right_o  = RIGHT_X;
  assign hit_o    = hit_q;
  assign miss_o   = miss_q;

endmodule

// File: rtl/block_lane_engine.sv
// rtl/block_lane_engine.sv - multi-lane falling-block engine: tick divider, press edges, lanes, score totals
module block_lane_engine #(
  parameter int NUM_LANES   = 4,
  parameter int TICK_DIV    = 833333,
  parameter int SPEED       = 4,
  parameter int BLOCK_H     = 20,
  parameter int BLOCK_W     = 80,
  parameter int LANE_X0     = 160,
  parameter int LANE_PITCH  = 120,
  parameter int HIT_Y_MIN   = 440,
  parameter int HIT_Y_MAX   = 470,
  parameter int SCREEN_H    = block_pkg::SCREEN_H,
  parameter int FLASH_TICKS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_LANES-1:0]                userin,
  input  logic [NUM_LANES-1:0]                spawn,
  output logic [block_pkg::Y_W*NUM_LANES-1:0] block_top,
  output logic [block_pkg::Y_W*NUM_LANES-1:0] block_bot,
  output logic [block_pkg::X_W*NUM_LANES-1:0] block_left,
  output logic [block_pkg::X_W*NUM_LANES-1:0] block_right,
  output logic [NUM_LANES-1:0]                block_active,
  output logic [NUM_LANES-1:0]                hit_pulse,
  output logic [NUM_LANES-1:0]                miss_pulse,
  output logic [15:0]                         score,
  output logic [15:0]                         miss_count
);
  import block_pkg::*;

  logic [31:0]          tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic [NUM_LANES-1:0] prev_q, prev_d;
  logic [NUM_LANES-1:0] armed_q, armed_d;
  logic [NUM_LANES-1:0] press;
  logic [15:0]          score_q, score_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;

  assign tick       = (tick_cnt_q == 32'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;

  // A button held through reset must be seen released before it can score.
  assign prev_d  = userin;
  assign armed_d = armed_q | ~userin;
  assign press   = userin & ~prev_q & armed_q;

  assign score_d    = sat_add16(score_q, popcount8(8'(hit_pulse)));
  assign miss_cnt_d = sat_add16(miss_cnt_q, popcount8(8'(miss_pulse)));

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      prev_q     <= '0;
      armed_q    <= '0;
      score_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign score      = score_q;
  assign miss_count = miss_cnt_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    block_lane #(
      .LANE_IDX    (i),
      .SPEED       (SPEED),
      .BLOCK_H     (BLOCK_H),
      .BLOCK_W     (BLOCK_W),
      .LANE_X0     (LANE_X0),
      .LANE_PITCH  (LANE_PITCH),
      .HIT_Y_MIN   (HIT_Y_MIN),
      .HIT_Y_MAX   (HIT_Y_MAX),
      .SCREEN_H    (SCREEN_H),
      .FLASH_TICKS (FLASH_TICKS)
    ) u_lane (
      .clk_i    (clk),
      .reset_i  (reset),
      .tick_i   (tick),
      .press_i  (press[i]),
      .spawn_i  (spawn[i]),
      .top_o    (block_top[Y_W*i +: Y_W]),
      .bot_o    (block_bot[Y_W*i +: Y_W]),
      .left_o   (block_left[X_W*i +: X_W]),
      .right_o  (block_right[X_W*i +: X_W]),
      .active_o (block_active[i]),
      .hit_o    (hit_pulse[i]),
      .miss_o   (miss_pulse[i])
    );
  end

endmodule
